// File: rtl/commit_trace_tx_pkg.sv
// ============================================================================
// Module   : commit_trace_tx_pkg
// Brief    : Shared types for the commit trace transmitter (record, FSM states).
// Config   : COMMIT_TRACE_SEQ_EN adds the per-record sequence byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package commit_trace_tx_pkg;

  localparam int XLEN       = 32;
  localparam int TRC_HDR_RW = 0;
  localparam int TRC_HDR_ST = 1;
  localparam int TRC_HDR_LD = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
`ifdef COMMIT_TRACE_SEQ_EN
    S_SEQ   = 3'd2,
`endif
    S_PC    = 3'd3,
    S_INSTR = 3'd4,
    S_RDATA = 3'd5,
    S_MADDR = 3'd6,
    S_MDATA = 3'd7
  } trace_state_e;

  typedef struct packed {
    logic [7:0]      hdr;
`ifdef COMMIT_TRACE_SEQ_EN
    logic [7:0]      seq;
`endif
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] maddr;
    logic [XLEN-1:0] mdata;
  } trace_rec_t;

  function automatic logic [7:0] word_byte(input logic [XLEN-1:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Byte presented on the stream for a given record, field state and byte index.
  function automatic logic [7:0] trc_byte(input trace_rec_t rec, input trace_state_e st,
                                          input logic [1:0] idx);
    logic [7:0] b;
    case (st)
      S_HDR:   b = rec.hdr;
`ifdef COMMIT_TRACE_SEQ_EN
      S_SEQ:   b = rec.seq;
`endif
      S_PC:    b = word_byte(rec.pc, idx);
      S_INSTR: b = word_byte(rec.instr, idx);
      S_RDATA: b = word_byte(rec.rdata, idx);
      S_MADDR: b = word_byte(rec.maddr, idx);
      S_MDATA: b = word_byte(rec.mdata, idx);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/commit_trace_tx_fifo.sv
// ============================================================================
// Module   : commit_trace_tx_fifo
// Brief    : Synchronous FIFO of trace records with head and next-head peek.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_tx_fifo
  import commit_trace_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  trace_rec_t data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       two_o,
  output trace_rec_t head_o,
  output trace_rec_t next_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  trace_rec_t  mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign two_o   = (count >= (AW+1)'(2));
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  // Peek lets the serialiser start the following header without a bubble.
  assign next_o  = mem_q[rd_ptr_q[AW-1:0] + AW'(1)];

endmodule

`default_nettype wire

// File: rtl/commit_trace_tx.sv
// ============================================================================
// Module   : commit_trace_tx
// Brief    : Captures commit records, buffers them and serialises a byte stream.
// Config   : COMMIT_TRACE_SEQ_EN inserts a sequence byte after each header.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_tx
  import commit_trace_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             update_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  instr_i,
  input  logic [4:0]       reg_addr_i,
  input  logic [XLEN-1:0]  reg_data_i,
  input  logic             register_file_write_enable_i,
  input  logic             memory_read_enable_i,
  input  logic [XLEN-1:0]  memory_read_addr_i,
  input  logic             memory_write_enable_i,
  input  logic [XLEN-1:0]  memory_write_addr_i,
  input  logic [XLEN-1:0]  memory_write_data_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             overflow_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  trace_state_e     state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`ifdef COMMIT_TRACE_SEQ_EN
  logic [7:0]       seq_q, seq_d;
`endif

  logic       capture, push, pop, drop;
  logic       fifo_full, fifo_empty, fifo_two;
  logic       st_f, ld_f, rw_f;
  logic       h_rw, h_st, h_ld;
  trace_rec_t rec_in, head, head_next;

  always_comb begin
    st_f   = memory_write_enable_i;
    ld_f   = memory_read_enable_i && (reg_addr_i != 5'd0) && !st_f;
    rw_f   = register_file_write_enable_i && (reg_addr_i != 5'd0) && !st_f && !ld_f;
    rec_in = '0;
    rec_in.hdr[TRC_HDR_RW] = rw_f;
    rec_in.hdr[TRC_HDR_ST] = st_f;
    rec_in.hdr[TRC_HDR_LD] = ld_f;
    rec_in.hdr[7:3]        = (rw_f || st_f || ld_f) ? reg_addr_i : 5'd0;
`ifdef COMMIT_TRACE_SEQ_EN
    rec_in.seq   = seq_q;
`endif
    rec_in.pc    = pc_i;
    rec_in.instr = instr_i;
    rec_in.rdata = reg_data_i;
    rec_in.maddr = st_f ? memory_write_addr_i : memory_read_addr_i;
    rec_in.mdata = memory_write_data_i;
  end

  // A full FIFO still accepts when its head leaves in the same cycle.
  assign capture = update_i && (pc_i != '0);
  assign push    = capture && (!fifo_full || pop);
  assign drop    = capture && !push;

  commit_trace_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .two_o   (fifo_two),
    .head_o  (head),
    .next_o  (head_next)
  );

  assign h_rw = head.hdr[TRC_HDR_RW];
  assign h_st = head.hdr[TRC_HDR_ST];
  assign h_ld = head.hdr[TRC_HDR_LD];

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  trace_state_e nxt_field;
  logic         nxt_end, word_st;

  always_comb begin
    nxt_field = S_IDLE;
    nxt_end   = 1'b0;
    word_st   = (state_q == S_PC) || (state_q == S_INSTR) || (state_q == S_RDATA) ||
                (state_q == S_MADDR) || (state_q == S_MDATA);
    case (state_q)
`ifdef COMMIT_TRACE_SEQ_EN
      S_HDR:   nxt_field = S_SEQ;
      S_SEQ:   nxt_field = S_PC;
`else
      S_HDR:   nxt_field = S_PC;
`endif
      S_PC:    nxt_field = S_INSTR;
      S_INSTR: begin
        if (h_rw || h_ld)  nxt_field = S_RDATA;
        else if (h_st)     nxt_field = S_MADDR;
        else               nxt_end   = 1'b1;
      end
      S_RDATA: begin
        if (h_ld) nxt_field = S_MADDR;
        else      nxt_end   = 1'b1;
      end
      S_MADDR: begin
        if (h_st) nxt_field = S_MDATA;
        else      nxt_end   = 1'b1;
      end
      default: nxt_end = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    pop     = 1'b0;
    if (state_q == S_IDLE) begin
      if (!fifo_empty) begin
        state_d = S_HDR;
        idx_d   = 2'd0;
        valid_d = 1'b1;
        data_d  = head.hdr;
      end
    end else if (tx_ready_i) begin
      if (word_st && (idx_q != 2'd3)) begin
        idx_d  = idx_q + 2'd1;
        data_d = trc_byte(head, state_q, idx_q + 2'd1);
      end else if (nxt_end) begin
        pop = 1'b1;
        if (fifo_two) begin
          state_d = S_HDR;
          idx_d   = 2'd0;
          data_d  = head_next.hdr;
        end else begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
          valid_d = 1'b0;
          data_d  = 8'h00;
        end
      end else begin
        state_d = nxt_field;
        idx_d   = 2'd0;
        data_d  = trc_byte(head, nxt_field, 2'd0);
      end
    end
  end

`ifdef COMMIT_TRACE_SEQ_EN
  // Dropped captures still consume a number so the host can see the gap.
  assign seq_d = capture ? seq_q + 8'd1 : seq_q;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef COMMIT_TRACE_SEQ_EN
      seq_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef COMMIT_TRACE_SEQ_EN
      seq_q      <= seq_d;
`endif
    end
  end

  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_tx.sv
// ============================================================================
// Module   : tb_commit_trace_tx
// Brief    : Scoreboard bench for commit_trace_tx (honours COMMIT_TRACE_SEQ_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_trace_tx;
  import commit_trace_tx_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
`ifdef COMMIT_TRACE_SEQ_EN
  localparam int SEQB = 1;
`else
  localparam int SEQB = 0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             update_i = 1'b0;
  logic [31:0]      pc_i = '0, instr_i = '0, reg_data_i = '0;
  logic [4:0]       reg_addr_i = '0;
  logic             register_file_write_enable_i = 1'b0;
  logic             memory_read_enable_i = 1'b0;
  logic [31:0]      memory_read_addr_i = '0;
  logic             memory_write_enable_i = 1'b0;
  logic [31:0]      memory_write_addr_i = '0, memory_write_data_i = '0;
  logic [7:0]       tx_data_o;
  logic             tx_valid_o;
  logic             tx_ready_i = 1'b1;
  logic             overflow_o;
  logic [CNT_W-1:0] drop_cnt_o;

  always #5 clk = ~clk;

  commit_trace_tx #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
    .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i),
    .register_file_write_enable_i(register_file_write_enable_i),
    .memory_read_enable_i(memory_read_enable_i), .memory_read_addr_i(memory_read_addr_i),
    .memory_write_enable_i(memory_write_enable_i), .memory_write_addr_i(memory_write_addr_i),
    .memory_write_data_i(memory_write_data_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  int         checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  logic [7:0] ref_log[$];
  int         len_q[$];
  int         sent = 0, m_drops = 0, xfer_cnt = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_seq = 8'h00;
  bit         chk_en = 1'b0;

  function automatic void push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endfunction

  // Reference: builds the expected byte record straight from the format rules.
  function automatic void model_capture();
    logic st, ld, rw;
    int   n0;
    n0 = exp_q.size();
    st = memory_write_enable_i;
    ld = memory_read_enable_i && reg_addr_i != 0 && !st;
    rw = register_file_write_enable_i && reg_addr_i != 0 && !st && !ld;
    exp_q.push_back((st || ld || rw) ? {reg_addr_i, ld, st, rw} : 8'h00);
    if (SEQB == 1) exp_q.push_back(m_seq);
    push_word(pc_i);
    push_word(instr_i);
    if (rw) push_word(reg_data_i);
    if (st) begin push_word(memory_write_addr_i); push_word(memory_write_data_i); end
    if (ld) begin push_word(reg_data_i); push_word(memory_read_addr_i); end
    len_q.push_back(exp_q.size() - n0);
  endfunction

  initial begin : p_model
    bit xfer, completing;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        exp_q.delete(); len_q.delete();
        sent = 0; m_drops = 0; m_ovf = 1'b0; m_seq = 8'h00;
      end else begin
        xfer       = tx_valid_o && tx_ready_i;
        completing = xfer && len_q.size() > 0 && (sent + 1 == len_q[0]);
        if (update_i && pc_i != 0) begin
          if (len_q.size() < DEPTH || completing) model_capture();
          else begin m_drops++; m_ovf = 1'b1; end
          m_seq = m_seq + 8'd1;
        end
        if (xfer && len_q.size() > 0) begin
          sent++;
          if (completing) begin void'(len_q.pop_front()); sent = 0; end
        end
      end
    end
  end

  initial begin : p_monitor
    logic       stall_prev;
    logic [7:0] data_prev, e;
    stall_prev = 1'b0;
    data_prev  = 8'h00;
    forever begin
      @(posedge clk);
      if (stall_prev) begin
        checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== data_prev) begin
          failures++;
          $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                   tx_valid_o, tx_data_o, data_prev);
        end
      end
      if (rstn && tx_valid_o && tx_ready_i) begin
        xfer_cnt++;
        rx_log.push_back(tx_data_o);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stream_byte: got %02h, required no byte (scoreboard empty)", tx_data_o);
        end else begin
          e = exp_q.pop_front();
          if (tx_data_o !== e) begin
            failures++;
            $display("FAIL stream_byte: got %02h, required %02h", tx_data_o, e);
          end
        end
      end
      stall_prev = rstn && tx_valid_o && !tx_ready_i;
      data_prev  = tx_data_o;
    end
  end

  initial begin : p_counters
    int sat;
    forever begin
      @(negedge clk);
      if (chk_en && rstn) begin
        sat = (m_drops > 65535) ? 65535 : m_drops;
        checks++;
        if (drop_cnt_o !== CNT_W'(sat) || overflow_o !== m_ovf) begin
          failures++;
          $display("FAIL drop_status: drop_cnt=%0d overflow=%0b, required drop_cnt=%0d overflow=%0b",
                   drop_cnt_o, overflow_o, sat, m_ovf);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                            input logic [31:0] rdata, input logic rwe, input logic mre,
                            input logic [31:0] raddr, input logic mwe,
                            input logic [31:0] waddr, input logic [31:0] wdata);
    update_i = 1'b1; pc_i = pc; instr_i = instr; reg_addr_i = rd; reg_data_i = rdata;
    register_file_write_enable_i = rwe; memory_read_enable_i = mre; memory_read_addr_i = raddr;
    memory_write_enable_i = mwe; memory_write_addr_i = waddr; memory_write_data_i = wdata;
  endtask

  task automatic commit1(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic rwe, input logic mre,
                         input logic [31:0] raddr, input logic mwe,
                         input logic [31:0] waddr, input logic [31:0] wdata);
    set_commit(pc, instr, rd, rdata, rwe, mre, raddr, mwe, waddr, wdata);
    @(negedge clk);
    update_i = 1'b0;
  endtask

  task automatic rand_commit();
    set_commit(($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
               1'($urandom), ($urandom_range(0, 2) == 0), $urandom,
               ($urandom_range(0, 3) == 0), $urandom, $urandom);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || tx_valid_o) begin
      failures++;
      $display("FAIL %s_drain: %0d bytes outstanding valid=%0b, required 0 outstanding and idle",
               name, exp_q.size(), tx_valid_o);
    end
  endtask

  task automatic check_log(input string name);
    logic [7:0] got[$];
    int         bad = -1;
    got = rx_log;
    if (SEQB == 1 && got.size() > 1) got.delete(1);
    checks++;
    if (got.size() != ref_log.size()) begin
      failures++;
      $display("FAIL %s_len: got %0d bytes, required %0d", name, got.size(), ref_log.size());
    end else begin
      foreach (got[i]) if (bad < 0 && got[i] !== ref_log[i]) bad = i;
      if (bad >= 0) begin
        failures++;
        $display("FAIL %s_byte%0d: got %02h, required %02h", name, bad, got[bad], ref_log[bad]);
      end
    end
  endtask

  logic [7:0] T1 [13] = '{8'h09, 8'h00, 8'h00, 8'h00, 8'h80, 8'h93, 8'h00, 8'h50, 8'h00,
                          8'h05, 8'h00, 8'h00, 8'h00};
  logic [7:0] T2 [17] = '{8'h02, 8'h04, 8'h00, 8'h00, 8'h80, 8'h23, 8'h20, 8'h11, 8'h00,
                          8'h00, 8'h10, 8'h00, 8'h80, 8'h05, 8'h00, 8'h00, 8'h00};

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    int base, n, bad;
    repeat (3) @(negedge clk);
    chk("reset_valid", tx_valid_o, 0);
    chk("reset_data", tx_data_o, 0);
    chk("reset_overflow", overflow_o, 0);
    chk("reset_drop_cnt", drop_cnt_o, 0);
    rstn = 1'b1; chk_en = 1'b1;
    @(negedge clk);

    // ALU record plus capture-to-header latency
    rx_log.delete();
    set_commit(32'h8000_0000, 32'h0050_0093, 5'd1, 32'd5, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    update_i = 1'b0;
    chk("t1_valid_after_N", tx_valid_o, 0);
    @(negedge clk);
    chk("t1_valid_after_N1", tx_valid_o, 1);
    chk("t1_hdr_after_N1", tx_data_o, 32'h09);
    drain("t1", 100);
    ref_log.delete(); foreach (T1[i]) ref_log.push_back(T1[i]);
    check_log("t1_alu");

    // Store record
    rx_log.delete();
    commit1(32'h8000_0004, 32'h0011_2023, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1,
            32'h8000_1000, 32'd5);
    drain("t2", 100);
    ref_log.delete(); foreach (T2[i]) ref_log.push_back(T2[i]);
    check_log("t2_store");

    // lw x0: no flags, header 0x00; then an update with pc==0
    rx_log.delete();
    commit1(32'h8000_0008, 32'h0000_2003, 5'd0, 32'h1234, 1'b1, 1'b1, 32'h8000_2000, 1'b0,
            32'h0, 32'h0);
    drain("t3", 100);
    chk("t3_len", rx_log.size(), 9 + SEQB);
    chk("t3_hdr", rx_log.size() > 0 ? rx_log[0] : 8'hxx, 0);
    commit1(32'h0, 32'h0050_0093, 5'd1, 32'd5, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    chk("t3_pc0_valid", tx_valid_o, 0);
    chk("t3_pc0_drop", drop_cnt_o, 0);

    // 10 back-to-back commits with the sink stalled
    tx_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_commit(32'h8000_0100 + 32'(4 * i), 32'h0000_0013 + 32'(i << 7), 5'(i + 1), 32'(i),
                 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
    update_i = 1'b0;
    chk("t4_drop_cnt", drop_cnt_o, 2);
    chk("t4_overflow", overflow_o, 1);
    tx_ready_i = 1'b1;
    drain("t4", 400);

    // Reset while mid-record with three records queued
    tx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_commit(32'h8000_0200 + 32'(4 * i), 32'h0000_0013, 5'd2, 32'(i), 1'b1, 1'b0, 32'h0,
                 1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
    update_i = 1'b0;
    tx_ready_i = 1'b1;
    base = xfer_cnt; n = 0;
    while (xfer_cnt - base < 3 + SEQB && n < 50) begin @(negedge clk); n++; end
    chk("t5_reached_pc_byte2", (xfer_cnt - base >= 3 + SEQB) ? 1 : 0, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_valid", tx_valid_o, 0);
    chk("t5_data", tx_data_o, 0);
    chk("t5_overflow", overflow_o, 0);
    chk("t5_drop_cnt", drop_cnt_o, 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_fifo_empty", tx_valid_o, 0);
    rx_log.delete();
    commit1(32'h8000_0300, 32'h00A0_0113, 5'd2, 32'd10, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    drain("t5", 100);
    chk("t5_next_hdr", rx_log.size() > 0 ? rx_log[0] : 8'hxx, 32'h11);

    // Randomised traffic with alternating heavy/light sink stalls
    for (int c = 0; c < 1200; c++) begin
      if (((c / 150) % 2) == 1) tx_ready_i = ($urandom_range(0, 7) == 0);
      else                      tx_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) rand_commit();
      else update_i = 1'b0;
      @(negedge clk);
    end
    update_i = 1'b0;
    tx_ready_i = 1'b1;
    drain("rand", 1000);

`ifdef COMMIT_TRACE_SEQ_EN
    // Sequence wrap across 258 commits
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    rx_log.delete();
    for (int k = 0; k < 258; k++) begin
      commit1(32'h8000_0000 + 32'(4 * k), 32'h0000_0013, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
              32'h0, 32'h0);
      repeat (11) @(negedge clk);
    end
    drain("seq", 200);
    bad = 0;
    for (int k = 0; k < 258; k++)
      if (k * 10 + 1 >= rx_log.size() || rx_log[k * 10 + 1] !== 8'(k)) bad++;
    chk("seq_wrap_bad_records", bad, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
